// File: rtl/icache_fetch_responder.sv
// ---------------------------------------------------------------------------
// icache_fetch_responder
//
// Direct-mapped instruction-cache read responder. The next-PC stage presents
// a physical fetch address every cycle; one cycle later the block returns the
// whole cache line together with a hit flag. Misses are refilled from the
// memory arbiter via a valid/ready request followed by a single-beat line
// response. A fence.i style flush walks the valid bits and clears them one
// index per cycle.
//
// Ports
//   clk             clock
//   rst             synchronous reset, active-low
//   nextReadAddrIn  physical fetch address, sampled every cycle
//   readEnable      fetch request valid for nextReadAddrIn
//   readHit         line for the previous cycle's address is present
//   readLineOut     line data, byte 0 in bits [7:0]
//   busy            refill or flush in progress, fetch must stall
//   flushReq        one-cycle pulse requesting a whole-cache invalidate
//   flushDone       one-cycle pulse when the invalidate walk completes
//   memReqValid     refill request valid
//   memReqAddr      line-aligned refill address
//   memReqReady     memory accepts the refill request
//   memRspValid     refill line valid (one beat)
//   memRspData      refill line
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | serving lookups, detecting misses
// MISS_REQ  | refill request presented, waiting for memReqReady
// MISS_WAIT | request accepted, waiting for memRspValid
// FILL      | writing the returned line, tag and valid bit
// FLUSH     | clearing one valid bit per cycle, index 0 upwards
// ---------------------------------------------------------------------------
module icache_fetch_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    parameter int INDEX_BITS = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   nextReadAddrIn,
    input  logic                    readEnable,
    output logic                    readHit,
    output logic [LINE_BYTES*8-1:0] readLineOut,
    output logic                    busy,
    input  logic                    flushReq,
    output logic                    flushDone,
    output logic                    memReqValid,
    output logic [ADDR_WIDTH-1:0]   memReqAddr,
    input  logic                    memReqReady,
    input  logic                    memRspValid,
    input  logic [LINE_BYTES*8-1:0] memRspData
);

    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
    localparam int LINES       = 1 << INDEX_BITS;
    localparam int LINE_W      = LINE_BYTES * 8;

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] MISS_REQ  = 3'd1;
    localparam logic [2:0] MISS_WAIT = 3'd2;
    localparam logic [2:0] FILL      = 3'd3;
    localparam logic [2:0] FLUSH     = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] regAddr;
    logic                  regEn;
    logic [ADDR_WIDTH-1:0] missAddr;
    logic                  flushPending;
    logic [INDEX_BITS-1:0] flushCnt;
    logic [LINES-1:0]      validBits;
    logic                  validQ;
    logic [TAG_BITS-1:0]   tagQ;
    logic [LINE_W-1:0]     lineQ;
    logic [LINE_W-1:0]     fillData;

    logic [LINE_W-1:0]     dataArr [LINES];
    logic [TAG_BITS-1:0]   tagArr  [LINES];

    logic [INDEX_BITS-1:0] rdIdx;
    logic [INDEX_BITS-1:0] missIdx;
    logic [TAG_BITS-1:0]   regTag;
    logic [TAG_BITS-1:0]   missTag;
    logic                  tagHit;
    logic                  missDetect;
    logic                  lastFlush;

    assign rdIdx      = nextReadAddrIn[OFFSET_BITS +: INDEX_BITS];
    assign regTag     = regAddr[ADDR_WIDTH-1 -: TAG_BITS];
    assign missIdx    = missAddr[OFFSET_BITS +: INDEX_BITS];
    assign missTag    = missAddr[ADDR_WIDTH-1 -: TAG_BITS];
    assign tagHit     = regEn && validQ && (tagQ == regTag);
    assign missDetect = regEn && !tagHit;
    assign lastFlush  = &flushCnt;

    // Control, valid bits and lookup registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            regAddr      <= '0;
            regEn        <= 1'b0;
            missAddr     <= '0;
            flushPending <= 1'b0;
            flushCnt     <= '0;
            validBits    <= '0;
            validQ       <= 1'b0;
        end else begin
            regAddr <= nextReadAddrIn;
            // Lookups sampled while stalled are discarded: the array may be
            // mid-update, and the requester re-presents the address anyway.
            regEn   <= readEnable && (state == IDLE);
            validQ  <= validBits[rdIdx];

            case (state)
                IDLE: begin
                    // A flush in the same cycle as a miss wins; the miss is
                    // simply dropped and re-requested after busy falls.
                    if (flushReq) begin
                        state    <= FLUSH;
                        flushCnt <= '0;
                    end else if (missDetect) begin
                        state    <= MISS_REQ;
                        missAddr <= regAddr & ~OFFSET_MASK;
                    end
                end
                MISS_REQ: begin
                    if (flushReq) begin
                        flushPending <= 1'b1;
                    end
                    if (memReqReady) begin
                        state <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (flushReq) begin
                        flushPending <= 1'b1;
                    end
                    if (memRspValid) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    validBits[missIdx] <= 1'b1;
                    if (flushPending || flushReq) begin
                        state        <= FLUSH;
                        flushCnt     <= '0;
                        flushPending <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    validBits[flushCnt] <= 1'b0;
                    if (lastFlush) begin
                        state <= IDLE;
                    end else begin
                        flushCnt <= flushCnt + INDEX_BITS'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line and tag storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        lineQ <= dataArr[rdIdx];
        tagQ  <= tagArr[rdIdx];
        if (state == MISS_WAIT && memRspValid) begin
            fillData <= memRspData;
        end
        if (rst && state == FILL) begin
            dataArr[missIdx] <= fillData;
            tagArr[missIdx]  <= missTag;
        end
    end

    assign busy        = (state != IDLE) || flushPending;
    assign readHit     = (state == IDLE) && !flushPending && tagHit;
    assign readLineOut = lineQ;
    assign flushDone   = (state == FLUSH) && lastFlush;
    assign memReqValid = (state == MISS_REQ);
    assign memReqAddr  = missAddr;

endmodule

// File: tb/tb_icache_fetch_responder.sv
module tb_icache_fetch_responder;

    logic         clk;
    logic         rst;
    logic [31:0]  nextReadAddrIn;
    logic         readEnable;
    logic         readHit;
    logic [127:0] readLineOut;
    logic         busy;
    logic         flushReq;
    logic         flushDone;
    logic         memReqValid;
    logic [31:0]  memReqAddr;
    logic         memReqReady;
    logic         memRspValid;
    logic [127:0] memRspData;

    icache_fetch_responder dut (
        .clk            (clk),
        .rst            (rst),
        .nextReadAddrIn (nextReadAddrIn),
        .readEnable     (readEnable),
        .readHit        (readHit),
        .readLineOut    (readLineOut),
        .busy           (busy),
        .flushReq       (flushReq),
        .flushDone      (flushDone),
        .memReqValid    (memReqValid),
        .memReqAddr     (memReqAddr),
        .memReqReady    (memReqReady),
        .memRspValid    (memRspValid),
        .memRspData     (memRspData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nApplied = 0;
    int nMiss    = 0;
    int hsCount  = 0;

    // Accepted refill requests, observed mid-cycle.
    always @(negedge clk) begin
        if (memReqValid === 1'b1 && memReqReady === 1'b1) begin
            hsCount++;
        end
    end

    // Reference cache contents, indexed by line index.
    bit           validM [64];
    logic [21:0]  tagM   [64];
    logic [127:0] dataM  [64];

    localparam logic [127:0] PAT = 128'h0F0E0D0C0B0A09080706050403020100;

    typedef struct {
        logic         rstV;
        logic         re;
        logic [31:0]  addr;
        logic         rdy;
        logic         rspV;
        logic [127:0] rspD;
        logic         expHit;
        logic         expBusy;
        logic         expReqV;
        logic [31:0]  expReqA;
        logic         chkLine;
        logic [127:0] expLine;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] lineOf(input logic [31:0] a);
        logic [31:0] la;
        la = a & ~32'hF;
        return {la ^ 32'hDEAD_0003, la ^ 32'h1234_0002, ~la, la + 32'h1};
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 64; i++) validM[i] = 1'b0;
    endtask

    // One fetch of address a; services a refill when the model predicts a miss.
    task automatic doRead(input logic [31:0] a, input logic [127:0] line,
                          input int stall, input int rspDly);
        int          idx;
        bit          expHit;
        int          hs0;
        logic [31:0] la;
        idx    = int'(a[9:4]);
        la     = a & ~32'hF;
        expHit = validM[idx] && (tagM[idx] == a[31:10]);
        hs0    = hsCount;
        readEnable = 1'b1; nextReadAddrIn = a; memReqReady = 1'b0; memRspValid = 1'b0;
        cyc();
        check("rd_hit", readHit, expHit);
        if (expHit) begin
            check("rd_line", readLineOut, dataM[idx]);
            readEnable = 1'b0;
        end else begin
            cyc();
            check("req_valid", memReqValid, 1);
            check("req_addr", memReqAddr, la);
            check("req_busy", busy, 1);
            for (int s = 0; s < stall; s++) begin
                memRspValid = 1'($urandom_range(0, 1));
                memRspData  = {4{$urandom()}};
                cyc();
                check("stall_valid", memReqValid, 1);
                check("stall_addr", memReqAddr, la);
            end
            memRspValid = 1'b0; memReqReady = 1'b1;
            cyc();
            check("wait_valid", memReqValid, 0);
            memReqReady = 1'b0;
            for (int d = 0; d < rspDly; d++) begin
                cyc();
                check("wait_busy", busy, 1);
            end
            memRspValid = 1'b1; memRspData = line;
            cyc();
            memRspValid = 1'b0; memRspData = '0;
            check("fill_busy", busy, 1);
            cyc();
            check("idle_busy", busy, 0);
            check("idle_nohit", readHit, 0);
            check("handshakes", hsCount - hs0, 1);
            validM[idx] = 1'b1; tagM[idx] = a[31:10]; dataM[idx] = line;
            cyc();
            check("reread_hit", readHit, 1);
            check("reread_line", readLineOut, line);
            readEnable = 1'b0;
        end
    endtask

    // Call right after the edge that entered the walk; expects 64 busy cycles
    // with flushDone only on the last one and no refill traffic.
    task automatic waitFlush(input string name);
        int k;
        int dones;
        int doneAt;
        bit quiet;
        k = 0; dones = 0; doneAt = -1; quiet = 1'b1;
        while (busy === 1'b1 && k < 200) begin
            k++;
            if (flushDone === 1'b1) begin
                dones++;
                doneAt = k;
            end
            if (memReqValid !== 1'b0) quiet = 1'b0;
            cyc();
        end
        check({name, "_len"}, k, 64);
        check({name, "_done_cnt"}, dones, 1);
        check({name, "_done_at"}, doneAt, 64);
        check({name, "_no_req"}, quiet, 1);
        check({name, "_done_low"}, flushDone, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          hs0;

        rst = 1'b0; readEnable = 1'b0; nextReadAddrIn = '0; flushReq = 1'b0;
        memReqReady = 1'b0; memRspValid = 1'b0; memRspData = '0;
        clearModel();

        //          rst  re   addr          rdy  rspV rspD | hit  busy reqV reqA          chk  line
        vecs[0] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 128'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_1004, 1'b1, 1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 128'h0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_1004, 1'b1, 1'b0, 128'h0, 1'b0, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 128'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_1004, 1'b1, 1'b0, 128'h0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 128'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_1004, 1'b0, 1'b1, PAT,    1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 128'h0};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_1004, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 128'h0};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_1004, 1'b0, 1'b0, 128'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, PAT};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_100C, 1'b0, 1'b0, 128'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, PAT};
        vecs[8] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 128'h0};

        for (int i = 0; i < 9; i++) begin
            rst = vecs[i].rstV; readEnable = vecs[i].re; nextReadAddrIn = vecs[i].addr;
            memReqReady = vecs[i].rdy; memRspValid = vecs[i].rspV; memRspData = vecs[i].rspD;
            cyc();
            check("vec_hit", readHit, vecs[i].expHit);
            check("vec_busy", busy, vecs[i].expBusy);
            check("vec_req_valid", memReqValid, vecs[i].expReqV);
            check("vec_flush_done", flushDone, 0);
            if (vecs[i].expReqV || !vecs[i].rstV) check("vec_req_addr", memReqAddr, vecs[i].expReqA);
            if (vecs[i].chkLine) check("vec_line", readLineOut, vecs[i].expLine);
        end
        check("vec_handshakes", hsCount, 1);
        memReqReady = 1'b0;
        validM[0] = 1'b1; tagM[0] = 22'(32'h1000 >> 10); dataM[0] = PAT;

        // Conflict miss on index 0.
        doRead(32'h0000_1400, lineOf(32'h1400), 0, 0);
        doRead(32'h0000_1000, PAT, 1, 0);
        doRead(32'h0000_1008, PAT, 0, 0);

        // Request backpressure for 5 cycles.
        doRead(32'h0000_2010, lineOf(32'h2010), 5, 2);

        // Flush from IDLE after filling four lines.
        for (int i = 0; i < 4; i++) begin
            a = 32'h0000_3000 + 32'(i * 16);
            doRead(a, lineOf(a), 0, 1);
        end
        flushReq = 1'b1;
        cyc();
        flushReq = 1'b0;
        waitFlush("idle_flush");
        clearModel();
        for (int i = 0; i < 4; i++) begin
            a = 32'h0000_3004 + 32'(i * 16);
            doRead(a, lineOf(a), 0, 0);
        end

        // Flush coinciding with miss detection: the miss is dropped.
        hs0 = hsCount;
        readEnable = 1'b1; nextReadAddrIn = 32'h0000_5040;
        cyc();
        check("fm_hit", readHit, 0);
        flushReq = 1'b1;
        cyc();
        flushReq = 1'b0; readEnable = 1'b0;
        check("fm_req_valid", memReqValid, 0);
        check("fm_busy", busy, 1);
        waitFlush("fm_flush");
        check("fm_handshakes", hsCount - hs0, 0);
        clearModel();

        // Flush arriving during MISS_WAIT.
        a = 32'h0000_6054;
        hs0 = hsCount;
        readEnable = 1'b1; nextReadAddrIn = a; memReqReady = 1'b1;
        cyc();
        check("fw_hit", readHit, 0);
        cyc();
        check("fw_req_valid", memReqValid, 1);
        check("fw_busy_req", busy, 1);
        cyc();
        memReqReady = 1'b0;
        check("fw_wait_valid", memReqValid, 0);
        check("fw_busy_wait", busy, 1);
        flushReq = 1'b1;
        cyc();
        flushReq = 1'b0;
        check("fw_busy_pend", busy, 1);
        memRspValid = 1'b1; memRspData = lineOf(a);
        cyc();
        memRspValid = 1'b0; readEnable = 1'b0;
        check("fw_busy_fill", busy, 1);
        cyc();
        check("fw_busy_flush", busy, 1);
        waitFlush("fw_flush");
        check("fw_handshakes", hsCount - hs0, 1);
        clearModel();
        doRead(a, lineOf(a), 0, 0);

        // Reset while a refill request is outstanding.
        doRead(32'h0000_7060, lineOf(32'h7060), 0, 0);
        readEnable = 1'b1; nextReadAddrIn = 32'h0000_8070; memReqReady = 1'b0;
        cyc();
        check("rs_hit", readHit, 0);
        cyc();
        check("rs_req_valid", memReqValid, 1);
        rst = 1'b0;
        cyc();
        check("rs_req_valid_off", memReqValid, 0);
        check("rs_busy", busy, 0);
        check("rs_req_addr", memReqAddr, 0);
        check("rs_hit_off", readHit, 0);
        rst = 1'b1; readEnable = 1'b0;
        clearModel();
        cyc();
        doRead(32'h0000_7060, lineOf(32'h7060), 0, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                flushReq = 1'b1;
                cyc();
                flushReq = 1'b0;
                waitFlush("rnd_flush");
                clearModel();
            end else begin
                a = {20'h0, 2'($urandom_range(0, 2)), 6'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 2'b00};
                doRead(a, lineOf(a), $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule

// File: doc/icache_fetch_responder.md
Name: icache_fetch_responder

Overview:
- Instruction-cache read responder serving the per-cycle physical fetch address issued by the next-PC stage; returns one cache line (FETCH_WIDTH instructions) with a hit flag one cycle later.
- Direct-mapped, valid-bit per line; a miss FSM refills from the memory side through a valid/ready request and valid response handshake.
- Supports a whole-cache invalidate (fence.i) walk.
- Sits between the next-PC/fetch stages and the memory access arbiter.

Parameters:
ADDR_WIDTH, 32, physical address width
LINE_BYTES, 16, bytes per line (power of 2; equals FETCH_WIDTH*4)
INDEX_BITS, 6, log2 of line count (64 lines)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
nextReadAddrIn  in  ADDR_WIDTH  physical fetch address, sampled every cycle
readEnable  in  1  request valid for nextReadAddrIn this cycle
readHit  out  1  line for address sampled previous cycle is present
readLineOut  out  LINE_BYTES*8  line data; byte 0 at bits [7:0]
busy  out  1  FSM not in IDLE (fetch must stall)
flushReq  in  1  one-cycle pulse: invalidate entire cache
flushDone  out  1  one-cycle pulse when invalidate walk completes
memReqValid  out  1  line refill request valid
memReqAddr  out  ADDR_WIDTH  line-aligned refill address
memReqReady  in  1  memory accepts request
memRspValid  in  1  refill data valid (one beat, whole line)
memRspData  in  LINE_BYTES*8  refill line

Behaviour:
- Address split: offset = log2(LINE_BYTES) LSBs, index = next INDEX_BITS, tag = remaining MSBs. memReqAddr always has offset bits = 0.
- Read pipeline: cycle t samples nextReadAddrIn/readEnable into regAddr/regEn and reads data/tag/valid arrays. In cycle t+1, readHit = regEn && valid[idx] && tag match && state==IDLE. readLineOut is the array data (don't-care when readHit=0).
- States: IDLE, MISS_REQ, MISS_WAIT, FILL, FLUSH.
- IDLE -> MISS_REQ when regEn && !hit in cycle t+1. Capture missAddr = line-aligned regAddr.
- MISS_REQ: memReqValid=1, memReqAddr=missAddr, both held stable until memReqReady. Go to MISS_WAIT in the cycle after memReqValid && memReqReady.
- MISS_WAIT: memReqValid=0. On memRspValid, latch data and go to FILL.
- FILL (1 cycle): write data, tag and valid=1 at the missAddr index, then go to IDLE.
- Requester re-presents the same address while stalled; a hit appears at the earliest 2 cycles after FILL (read in IDLE cycle, result next cycle).
- memRspValid outside MISS_WAIT is ignored.
- FLUSH: entered from IDLE on flushReq, or on return to IDLE if a flush is pending.
  - Clears valid[cnt] for cnt = 0 .. 2^INDEX_BITS-1, one per cycle (64 cycles).
  - flushDone=1 in the cycle the last index is cleared, then go to IDLE.
  - readHit=0 throughout.
- flushReq during MISS_REQ/MISS_WAIT/FILL sets flushPending. The refill completes normally (request not abandoned); FLUSH starts the cycle after FILL, skipping IDLE miss detection.
- flushReq during FLUSH is ignored (already covered).
- flushReq in IDLE in the same cycle a miss is detected: FLUSH wins and the miss is dropped. Requester re-requests after busy deasserts.
- busy = (state != IDLE) || flushPending. readHit=0 whenever busy.
- Reset (rst=0), including mid-refill:
  - state=IDLE, all valid bits=0, regEn=0, flushPending=0, counter=0.
  - Outputs: readHit=0, busy=0, flushDone=0, memReqValid=0, memReqAddr=0.
  - The memory side is reset in the same cycle, so no stale response arrives after reset.
- Data/tag arrays are not reset.

Test Plan:
- After reset, readEnable=1, addr 0x0000_1004 with memReqReady=1 → next cycle readHit=0; then memReqValid=1 with memReqAddr=0x0000_1000. Respond with memRspValid and data 0x0F0E..0100 → busy falls after FILL; re-read of 0x1004 gives readHit=1 and readLineOut=0x0F0E..0100.
- Conflict miss: fill 0x1000, then read 0x1400 (same index 0, different tag) → readHit=0 and a refill at 0x1400. A following read of 0x1000 misses again.
- Backpressure: hold memReqReady=0 for 5 cycles → memReqValid and memReqAddr stay stable for those 5 cycles. The request is accepted exactly once, confirmed by counting valid&&ready handshakes = 1.
- Flush in IDLE: fill 4 lines, pulse flushReq → busy=1 for 64 cycles, flushDone pulses once on cycle 64. All 4 addresses miss afterwards.
- Flush during MISS_WAIT → refill completes, FLUSH follows immediately, and the refilled line is invalid afterwards. busy stays 1 continuously from the miss until flushDone.
- Drive rst=0 in MISS_REQ while memReqValid=1 → next cycle memReqValid=0 and busy=0, and a read of the previously valid line misses.
